wb_commit_ctrl: RTL

WB_COMMIT_CTRL -- requirements
Module: wb_commit_ctrl

---
 rtl/wb_commit_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/wb_commit_ctrl.sv
// wb_commit_ctrl -- write-back commit / trap controller.
//
// Decides, for the instruction held in the WB stage, whether it retires
// normally, enters a machine trap (timer interrupt or ecall), or returns
// from a trap (mret). Normal retirement is combinational in RUN. A trap
// takes RUN -> SAVE (CSR update) -> JUMP (redirect to mtvec). An mret takes
// RUN -> JUMP (redirect to mepc). SAVE and JUMP act only on latched state.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   wb_valid / wb_ready      WB instruction present / may be consumed
//   i_isecall, i_ismret,
//   i_iscsr, i_RegWr         WB instruction attributes
//   clint_mtip, mstatus_mie,
//   mie_mtie                 timer interrupt pending and its enables
//   i_wb_pc, mtvec, mepc     WB pc, trap vector CSR, return address CSR
//   rf_wen, commit_valid     regfile write enable, retire strobe
//   flush, redirect_valid,
//   redirect_pc              pipeline kill and fetch redirect
//   trap_wen, trap_mepc,
//   trap_mcause, mret_wen    CSR update strobes/data
//   minstret                 retired-instruction counter
module wb_commit_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic        i_isecall,
    input  logic        i_ismret,
    input  logic        i_iscsr,
    input  logic        i_RegWr,
    input  logic        clint_mtip,
    input  logic        mstatus_mie,
    input  logic        mie_mtie,
    input  logic [63:0] i_wb_pc,
    input  logic [63:0] mtvec,
    input  logic [63:0] mepc,
    output logic        rf_wen,
    output logic        commit_valid,
    output logic        flush,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc,
    output logic        trap_wen,
    output logic [63:0] trap_mepc,
    output logic [63:0] trap_mcause,
    output logic        mret_wen,
    output logic [63:0] minstret
);

    localparam logic [63:0] CAUSE_IRQ   = 64'h8000_0000_0000_0007;
    localparam logic [63:0] CAUSE_ECALL = 64'h0000_0000_0000_000B;

    typedef enum logic [1:0] {RUN, SAVE, JUMP} state_t;

    state_t      state_q, state_d;
    logic [63:0] mepc_q, mcause_q, tgt_q, minstret_q;
    logic        mret_q;
    logic        irq_take;
    logic        trap_ld, mret_ld;

    assign irq_take = wb_valid & clint_mtip & mstatus_mie & mie_mtie;

    always_comb begin
        state_d        = state_q;
        trap_ld        = 1'b0;
        mret_ld        = 1'b0;
        wb_ready       = 1'b0;
        rf_wen         = 1'b0;
        commit_valid   = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        trap_wen       = 1'b0;
        trap_mepc      = '0;
        trap_mcause    = '0;
        mret_wen       = 1'b0;
        minstret       = '0;
        if (!rst) begin
            minstret = minstret_q;
            case (state_q)
                RUN: begin
                    wb_ready = 1'b1;
                    if (wb_valid) begin
                        if (irq_take || i_isecall) begin
                            wb_ready = 1'b0;
                            trap_ld  = 1'b1;
                            state_d  = SAVE;
                        end else if (i_ismret) begin
                            wb_ready = 1'b0;
                            mret_ld  = 1'b1;
                            state_d  = JUMP;
                        end else begin
                            commit_valid = 1'b1;
                            // CSR instructions retire like any other; their
                            // write-back is still gated by i_RegWr alone.
                            rf_wen = i_RegWr | (i_iscsr & i_RegWr);
                        end
                    end
                end
                SAVE: begin
                    trap_wen    = 1'b1;
                    trap_mepc   = mepc_q;
                    trap_mcause = mcause_q;
                    flush       = 1'b1;
                    state_d     = JUMP;
                end
                JUMP: begin
                    // tgt_q holds either the aligned mtvec or mepc, chosen at entry.
                    redirect_valid = 1'b1;
                    redirect_pc    = tgt_q;
                    flush          = 1'b1;
                    wb_ready       = 1'b1;
                    mret_wen       = mret_q;
                    commit_valid   = mret_q;
                    state_d        = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            mepc_q     <= '0;
            mcause_q   <= '0;
            tgt_q      <= '0;
            mret_q     <= 1'b0;
            minstret_q <= '0;
        end else begin
            state_q <= state_d;
            if (trap_ld) begin
                mepc_q   <= i_wb_pc;
                mcause_q <= irq_take ? CAUSE_IRQ : CAUSE_ECALL;
                tgt_q    <= mtvec & ~64'h3;
                mret_q   <= 1'b0;
            end
            if (mret_ld) begin
                tgt_q  <= mepc;
                mret_q <= 1'b1;
            end
            if (commit_valid) begin
                minstret_q <= minstret_q + 64'd1;
            end
        end
    end

endmodule
